rr_arb4: RTL and testbench
==========================

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 15, maximum grant length in cycles (legal range 1..255), used only when RR_ARB4_TIMEOUT_EN is defined.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, with the ports listed in REQ-003 to REQ-010.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  4  request vector; bit i means requester i wants its data routed through the downstream 4:1 mux.
REQ-006 release  input  1  current owner is done; sampled only in BUSY.
REQ-007 sel  output  2  registered select; drives the sel input of the downstream 4:1 mux.
REQ-008 gnt  output  4  registered one-hot grant; equals 1<<sel while gnt_valid is high, else 0.
REQ-009 gnt_valid  output  1  registered; high while a grant is held.
REQ-010 timeout  output  1  registered one-cycle pulse; the grant was force-released.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 IDLE with req==0: the block SHALL stay in IDLE; sel, gnt, gnt_valid and last SHALL be unchanged or zero as specified.
REQ-013 IDLE with req!=0: at the clock edge the block SHALL choose the first set req bit scanning last+1, last+2, last+3, last (mod 4), load its index into sel, set gnt=1<<index and gnt_valid=1, and go to BUSY; gnt_valid is high in the cycle after req is sampled.
REQ-014 BUSY: sel and gnt SHALL be held regardless of req changes, including deassertion of the owner's req bit (no preemption).
REQ-015 BUSY with release=1: at the edge the block SHALL set last=sel, gnt_valid=0, gnt=0, return to IDLE, and keep sel at its last value.
REQ-016 After every release the block SHALL spend at least one cycle in IDLE, so back-to-back grants are separated by one cycle with gnt_valid=0.
REQ-017 release SHALL be ignored in IDLE.
REQ-018 The round-robin pointer last SHALL be 2 bits and wrap 3->0; only one requester SHALL be granted at a time.
REQ-019 Requester i held continuously high SHALL be granted within 4 grant cycles (fairness).

Reset
REQ-020 rst SHALL be sampled only on the rising clock edge and SHALL override all other inputs.
REQ-021 On reset: state=IDLE, sel=0, gnt=0, gnt_valid=0, timeout=0, last=3 (so requester 0 has first priority), hold counter=0.
REQ-022 Reset asserted during BUSY SHALL drop the grant at that edge without updating last beyond the reset value 3.

Configuration
REQ-023 Macro RR_ARB4_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-024 With the macro, if BUSY and counter==MAX_HOLD-1 and release=0, the block SHALL force a release exactly as in REQ-015; gnt_valid is then high for exactly MAX_HOLD cycles.
REQ-025 With the macro, a forced release SHALL pulse timeout high for the first IDLE cycle only.
REQ-026 With the macro, if release=1 coincides with counter==MAX_HOLD-1, this SHALL be a normal release with timeout=0.
REQ-027 Macro undefined: no counter SHALL exist, timeout SHALL be tied to 0, and a grant SHALL be held until release.

Verification
REQ-028 Reset, then req=4'b0001 -> next cycle sel=0, gnt=4'b0001, gnt_valid=1; release pulse -> gnt_valid=0 next cycle.
REQ-029 req=4'b1111 held, release one cycle after each grant -> sel sequence 0,1,2,3,0 with one idle cycle between grants.
REQ-030 last=1 (after a grant to 1), req=4'b0001 -> sel=0 (wrap-around search); then req=4'b1001 -> sel=3.
REQ-031 Grant to 2, then req drops to 4'b0000 while release stays 0 for 10 cycles -> sel=2 and gnt_valid=1 throughout.
REQ-032 With RR_ARB4_TIMEOUT_EN and MAX_HOLD=4, req=4'b0010 and no release -> gnt_valid high for exactly 4 cycles, then timeout=1 for 1 cycle; release on the 4th cycle -> timeout stays 0.
REQ-033 rst asserted in the middle of BUSY with sel=3 -> next cycle gnt_valid=0 and sel=0; req=4'b1000 then grants sel=3 only after requester 0 priority is checked (last=3).

Source files
------------

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter with held grants and registered mux select.
// Optional forced release after MAX_HOLD cycles when RR_ARB4_TIMEOUT_EN is defined.
module rr_arb4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    // owner-done strobe; "release" itself is a reserved word in SystemVerilog
    input  logic       rel,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 1..255");
    end

    logic [0:0] state;
    logic [1:0] last;
    logic [1:0] pick;
    logic       found;

`ifdef RR_ARB4_TIMEOUT_EN
    localparam logic [7:0] HOLD_END = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
`endif

    // Scan last+1 .. last+4 (mod 4) and take the first requester found
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] idx;
            idx = last + k[1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Arbitration FSM: grant in IDLE, hold in BUSY until (forced) release
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            gnt       <= 4'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            last      <= 2'd3;
`ifdef RR_ARB4_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel       <= pick;
                        gnt       <= 4'(4'b0001 << pick);
                        gnt_valid <= 1'b1;
                        state     <= BUSY;
`ifdef RR_ARB4_TIMEOUT_EN
                        hold_cnt  <= 8'd0;
`endif
                    end
                end
                BUSY: begin
                    if (rel) begin
                        last      <= sel;
                        gnt       <= 4'd0;
                        gnt_valid <= 1'b0;
                        state     <= IDLE;
`ifdef RR_ARB4_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_END) begin
                        last      <= sel;
                        gnt       <= 4'd0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt  <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed self-checking bench for rr_arb4.
// Timeout scenarios run only when RR_ARB4_TIMEOUT_EN is defined.
module tb_rr_arb4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int tests;
    int fails;

    rr_arb4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge; inputs and checks happen 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        req = 4'b1111;
        rel = 1'b1;
        step();
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0000_0_0) begin
            fails++;
            $display("FAIL reset_state obs=%b exp=%b", obs, 8'b00_0000_0_0);
        end
        rst = 1'b0;
        req = 4'b0000;
        rel = 1'b0;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0000_0_0) begin
            fails++;
            $display("FAIL idle_no_req obs=%b exp=%b", obs, 8'b00_0000_0_0);
        end
    endtask

    task automatic test_basic();
        logic [7:0] obs;
        req = 4'b0001;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0001_1_0) begin
            fails++;
            $display("FAIL basic_grant obs=%b exp=%b", obs, 8'b00_0001_1_0);
        end
        req = 4'b0000;
        rel = 1'b1;
        step();
        rel = 1'b0;
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0000_0_0) begin
            fails++;
            $display("FAIL basic_release obs=%b exp=%b", obs, 8'b00_0000_0_0);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_sel [5];
        logic [7:0] obs;
        logic [7:0] exp;
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            obs = {sel, gnt, gnt_valid, timeout};
            exp = {exp_sel[i], 4'(4'b0001 << exp_sel[i]), 1'b1, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL rotate_grant[%0d] obs=%b exp=%b", i, obs, exp);
            end
            rel = 1'b1;
            step();
            rel = 1'b0;
            obs = {sel, gnt, gnt_valid, timeout};
            exp = {exp_sel[i], 4'b0000, 1'b0, 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL rotate_gap[%0d] obs=%b exp=%b", i, obs, exp);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [7:0] obs;
        req = 4'b0010;
        step();
        req = 4'b0000;
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 4'b0001;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0001_1_0) begin
            fails++;
            $display("FAIL wrap_to_0 obs=%b exp=%b", obs, 8'b00_0001_1_0);
        end
        req = 4'b0000;
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 4'b1001;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b11_1000_1_0) begin
            fails++;
            $display("FAIL skip_to_3 obs=%b exp=%b", obs, 8'b11_1000_1_0);
        end
        req = 4'b0000;
        rel = 1'b1;
        step();
        // release in IDLE must do nothing; sel keeps its last value
        step();
        rel = 1'b0;
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b11_0000_0_0) begin
            fails++;
            $display("FAIL rel_in_idle obs=%b exp=%b", obs, 8'b11_0000_0_0);
        end
    endtask

    task automatic test_no_preempt();
        logic [7:0] obs;
        int bad;
        req = 4'b0100;
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            req = (i % 2 == 0) ? 4'b0000 : 4'b1011;
            step();
            obs = {sel, gnt, gnt_valid, timeout};
            if (obs !== 8'b10_0100_1_0) bad++;
        end
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_no_preempt bad_cycles=%0d last_obs=%b exp=%b",
                     bad, obs, 8'b10_0100_1_0);
        end
        req = 4'b0000;
        rel = 1'b1;
        step();
        rel = 1'b0;
    endtask

    task automatic test_reset_busy();
        logic [7:0] obs;
        req = 4'b1000;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b11_1000_1_0) begin
            fails++;
            $display("FAIL pre_reset_grant obs=%b exp=%b", obs, 8'b11_1000_1_0);
        end
        rst = 1'b1;
        req = 4'b1111;
        rel = 1'b0;
        step();
        rst = 1'b0;
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0000_0_0) begin
            fails++;
            $display("FAIL reset_in_busy obs=%b exp=%b", obs, 8'b00_0000_0_0);
        end
        req = 4'b1001;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b00_0001_1_0) begin
            fails++;
            $display("FAIL post_reset_prio0 obs=%b exp=%b", obs, 8'b00_0001_1_0);
        end
        req = 4'b1000;
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b11_1000_1_0) begin
            fails++;
            $display("FAIL post_reset_3 obs=%b exp=%b", obs, 8'b11_1000_1_0);
        end
        req = 4'b0000;
        rel = 1'b1;
        step();
        rel = 1'b0;
    endtask

`ifdef RR_ARB4_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] obs;
        int hi;
        req = 4'b0010;
        step();
        req = 4'b0000;
        hi = 0;
        while (gnt_valid === 1'b1 && hi < 20) begin
            hi++;
            step();
        end
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (hi != 4) begin
            fails++;
            $display("FAIL timeout_hold_len obs=%0d exp=%0d", hi, 4);
        end
        tests++;
        if (obs !== 8'b01_0000_0_1) begin
            fails++;
            $display("FAIL timeout_pulse obs=%b exp=%b", obs, 8'b01_0000_0_1);
        end
        step();
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b01_0000_0_0) begin
            fails++;
            $display("FAIL timeout_one_cycle obs=%b exp=%b", obs, 8'b01_0000_0_0);
        end
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b01_0000_0_0) begin
            fails++;
            $display("FAIL rel_at_limit obs=%b exp=%b", obs, 8'b01_0000_0_0);
        end
    endtask
`else
    task automatic test_hold_forever();
        logic [7:0] obs;
        int bad;
        req = 4'b0010;
        step();
        req = 4'b0000;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            obs = {sel, gnt, gnt_valid, timeout};
            if (obs !== 8'b01_0010_1_0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_forever bad_cycles=%0d exp=%0d", bad, 0);
        end
        rel = 1'b1;
        step();
        rel = 1'b0;
        obs = {sel, gnt, gnt_valid, timeout};
        tests++;
        if (obs !== 8'b01_0000_0_0) begin
            fails++;
            $display("FAIL hold_release obs=%b exp=%b", obs, 8'b01_0000_0_0);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_wrap();
        test_no_preempt();
        test_reset_busy();
`ifdef RR_ARB4_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
